// File: rtl/asm_dp_if.sv
// Command, status and result-handshake bundle between the ASM controller/host and asm_datapath.
// Optional wrap_cnt signal present only when DP_WRAPCNT_EN is defined.
interface asm_dp_if #(
  parameter int unsigned A_WIDTH = 4
) ();

  logic                 clr_AF;
  logic                 incr_A;
  logic                 set_E;
  logic                 clr_E;
  logic                 set_F;
  logic                 res_ack;

  logic                 A2;
  logic                 A3;
  logic [A_WIDTH-1:0]   a_val;
  logic                 e_flag;
  logic                 f_flag;
  logic [A_WIDTH+1:0]   res_data;
  logic                 res_valid;
  logic                 cmd_err;
  logic                 ovr_err;
`ifdef DP_WRAPCNT_EN
  logic [7:0]           wrap_cnt;
`endif

  // Controller/host side: issues commands and acknowledges results
  modport master (
`ifdef DP_WRAPCNT_EN
    input  wrap_cnt,
`endif
    output clr_AF, incr_A, set_E, clr_E, set_F, res_ack,
    input  A2, A3, a_val, e_flag, f_flag, res_data, res_valid, cmd_err, ovr_err
  );

  // Datapath side
  modport slave (
`ifdef DP_WRAPCNT_EN
    output wrap_cnt,
`endif
    input  clr_AF, incr_A, set_E, clr_E, set_F, res_ack,
    output A2, A3, a_val, e_flag, f_flag, res_data, res_valid, cmd_err, ovr_err
  );

endinterface

// File: rtl/asm_datapath.sv
// Datapath under the ASM controller: counter A, flags E/F, result capture with valid/ack.
// Define DP_WRAPCNT_EN to add the saturating wrap_cnt output.
module asm_datapath #(
  parameter int unsigned A_WIDTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  asm_dp_if.slave  bus
);

  localparam int unsigned RW = A_WIDTH + 2;

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [A_WIDTH-1:0] a_q, a_d;
  logic               e_q, e_d;
  logic               f_q, f_d;
  logic [RW-1:0]      res_q, res_d;
  logic [0:0]         state_q, state_d;
  logic               cmd_err_q, cmd_err_d;
  logic               ovr_err_q, ovr_err_d;
  logic               capture_c;
  logic               conflict_c;
`ifdef DP_WRAPCNT_EN
  logic [7:0]         wrap_q, wrap_d;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q       <= '0;
      e_q       <= 1'b0;
      f_q       <= 1'b0;
      res_q     <= '0;
      state_q   <= ST_EMPTY;
      cmd_err_q <= 1'b0;
      ovr_err_q <= 1'b0;
`ifdef DP_WRAPCNT_EN
      wrap_q    <= 8'h00;
`endif
    end else begin
      a_q       <= a_d;
      e_q       <= e_d;
      f_q       <= f_d;
      res_q     <= res_d;
      state_q   <= state_d;
      cmd_err_q <= cmd_err_d;
      ovr_err_q <= ovr_err_d;
`ifdef DP_WRAPCNT_EN
      wrap_q    <= wrap_d;
`endif
    end
  end

  // Command decode, register transfers and result state machine
  always_comb begin
    a_d        = a_q;
    e_d        = e_q;
    f_d        = f_q;
    res_d      = res_q;
    state_d    = state_q;
    cmd_err_d  = cmd_err_q;
    ovr_err_d  = ovr_err_q;
`ifdef DP_WRAPCNT_EN
    wrap_d     = wrap_q;
`endif

    capture_c  = bus.set_F & ~bus.clr_AF;
    conflict_c = (bus.set_E & bus.clr_E) |
                 (bus.clr_AF & bus.incr_A) |
                 (bus.clr_AF & bus.set_F);

    if (bus.clr_AF) begin
      a_d = '0;
    end else if (bus.incr_A) begin
      a_d = a_q + A_WIDTH'(1);
    end

`ifdef DP_WRAPCNT_EN
    if (bus.clr_AF) begin
      wrap_d = 8'h00;
    end else if (bus.incr_A && (&a_q) && (wrap_q != 8'hFF)) begin
      wrap_d = wrap_q + 8'd1;
    end
`endif

    if (bus.clr_AF) begin
      f_d = 1'b0;
    end else if (bus.set_F) begin
      f_d = 1'b1;
    end

    // Simultaneous set/clear of E leaves it unchanged
    if (bus.set_E && !bus.clr_E) begin
      e_d = 1'b1;
    end else if (bus.clr_E && !bus.set_E) begin
      e_d = 1'b0;
    end

    if (conflict_c) begin
      cmd_err_d = 1'b1;
    end

    if (capture_c) begin
      res_d = {1'b1, e_d, a_d};
    end

    case (state_q)
      ST_EMPTY: begin
        if (capture_c) begin
          state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        if (capture_c) begin
          state_d = ST_FULL;
          if (!bus.res_ack) begin
            ovr_err_d = 1'b1;
          end
        end else if (bus.res_ack) begin
          state_d = ST_EMPTY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  assign bus.A2        = a_q[2];
  assign bus.A3        = a_q[3];
  assign bus.a_val     = a_q;
  assign bus.e_flag    = e_q;
  assign bus.f_flag    = f_q;
  assign bus.res_data  = res_q;
  assign bus.res_valid = (state_q == ST_FULL);
  assign bus.cmd_err   = cmd_err_q;
  assign bus.ovr_err   = ovr_err_q;
`ifdef DP_WRAPCNT_EN
  assign bus.wrap_cnt  = wrap_q;
`endif

endmodule

// File: tb/tb_asm_datapath.sv
// Scoreboard bench for asm_datapath: directed spec scenarios followed by random commands.
module tb_asm_datapath;

  localparam int unsigned AW  = 4;
  localparam int          MOD = 1 << AW;

  typedef struct packed {
    logic          a2;
    logic          a3;
    logic [AW-1:0] a;
    logic          e;
    logic          f;
    logic          valid;
    logic [AW+1:0] data;
    logic          cerr;
    logic          oerr;
    logic [7:0]    wrap;
  } snap_t;

  logic clk;
  logic rst;

  asm_dp_if #(.A_WIDTH(AW)) bus ();

  asm_datapath #(.A_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int     n_checks = 0;
  int     n_pass   = 0;
  int     cyc      = 0;
  snap_t  exp_q[$];

  // Reference model state
  int            m_a;
  int            m_wrap;
  bit            m_e, m_f, m_v, m_cerr, m_oerr;
  logic [AW+1:0] m_data;

  function automatic snap_t model_snap();
    snap_t s;
    s.a2    = 1'((m_a >> 2) & 1);
    s.a3    = 1'((m_a >> 3) & 1);
    s.a     = AW'(m_a);
    s.e     = m_e;
    s.f     = m_f;
    s.valid = m_v;
    s.data  = m_data;
    s.cerr  = m_cerr;
    s.oerr  = m_oerr;
    s.wrap  = 8'(m_wrap);
    return s;
  endfunction

  task automatic step(input bit r, input bit c, input bit i, input bit se,
                      input bit ce, input bit sf, input bit ak);
    bit cap;
    @(negedge clk);
    rst         = r;
    bus.clr_AF  = c;
    bus.incr_A  = i;
    bus.set_E   = se;
    bus.clr_E   = ce;
    bus.set_F   = sf;
    bus.res_ack = ak;
    if (r) begin
      m_a = 0; m_wrap = 0; m_e = 0; m_f = 0; m_v = 0;
      m_cerr = 0; m_oerr = 0; m_data = '0;
    end else begin
      if ((se && ce) || (c && i) || (c && sf)) m_cerr = 1;
      cap = sf && !c;
`ifdef DP_WRAPCNT_EN
      if (c) m_wrap = 0;
      else if (i && m_a == MOD - 1 && m_wrap < 255) m_wrap = m_wrap + 1;
`endif
      if (c) m_a = 0;
      else if (i) m_a = (m_a + 1) % MOD;
      if (se && !ce) m_e = 1;
      else if (ce && !se) m_e = 0;
      if (c) m_f = 0;
      else if (sf) m_f = 1;
      if (cap) begin
        if (m_v && !ak) m_oerr = 1;
        m_data = {1'b1, m_e, AW'(m_a)};
        m_v    = 1;
      end else if (m_v && ak) begin
        m_v = 0;
      end
    end
    exp_q.push_back(model_snap());
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: compares every DUT output snapshot against the next queued expectation
  initial begin
    snap_t got, exp;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        got.a2    = bus.A2;
        got.a3    = bus.A3;
        got.a     = bus.a_val;
        got.e     = bus.e_flag;
        got.f     = bus.f_flag;
        got.valid = bus.res_valid;
        got.data  = bus.res_data;
        got.cerr  = bus.cmd_err;
        got.oerr  = bus.ovr_err;
`ifdef DP_WRAPCNT_EN
        got.wrap  = bus.wrap_cnt;
`else
        got.wrap  = 8'h00;
`endif
        n_checks++;
        if (got !== exp) begin
          $display("FAIL outputs cyc=%0d got a=%h A2=%b A3=%b e=%b f=%b v=%b d=%h cerr=%b oerr=%b wrap=%h required a=%h A2=%b A3=%b e=%b f=%b v=%b d=%h cerr=%b oerr=%b wrap=%h",
                   cyc, got.a, got.a2, got.a3, got.e, got.f, got.valid, got.data, got.cerr, got.oerr, got.wrap,
                   exp.a, exp.a2, exp.a3, exp.e, exp.f, exp.valid, exp.data, exp.cerr, exp.oerr, exp.wrap);
        end else begin
          n_pass++;
        end
      end
    end
  end

  initial begin
    int r, c, i, se, ce, sf, ak;
    rst = 1'b1;
    bus.clr_AF = 0; bus.incr_A = 0; bus.set_E = 0;
    bus.clr_E = 0; bus.set_F = 0; bus.res_ack = 0;

    // Reset for two cycles
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);

    // Count to 4 then 8
    step(0, 1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 8; k++) step(0, 0, 1, 0, 0, 0, 0);

    // Run up to all-ones, wrap, then an idle cycle
    for (int k = 0; k < 7; k++) step(0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0);
    idle(1);

    // Capture with E set, then acknowledge
    step(0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    idle(1);
    step(0, 0, 0, 0, 0, 0, 1);
    idle(1);
    step(0, 0, 0, 0, 0, 0, 1);

    // Overrun: two captures without ack
    step(0, 0, 1, 0, 0, 1, 0);
    step(0, 0, 1, 0, 1, 1, 0);
    step(0, 0, 0, 0, 0, 0, 1);

    // Reset, then capture followed by capture+ack: no overrun
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 1, 0, 1, 0);
    step(0, 0, 1, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0, 0, 1);

    // Conflicting E commands, reset, then clr_AF with incr_A
    step(0, 0, 0, 1, 1, 0, 0);
    idle(1);
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 1, 0);
    idle(1);

    // Randomized command stream
    for (int k = 0; k < 800; k++) begin
      r  = ($urandom_range(0, 79) == 0) ? 1 : 0;
      c  = ($urandom_range(0, 11) == 0) ? 1 : 0;
      i  = ($urandom_range(0, 1)  == 0) ? 1 : 0;
      se = ($urandom_range(0, 4)  == 0) ? 1 : 0;
      ce = ($urandom_range(0, 4)  == 0) ? 1 : 0;
      sf = ($urandom_range(0, 5)  == 0) ? 1 : 0;
      ak = ($urandom_range(0, 2)  == 0) ? 1 : 0;
      step(r[0], c[0], i[0], se[0], ce[0], sf[0], ak[0]);
    end

    idle(2);
    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
